// File: rtl/adxl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | adxl_pkg : states, command bytes and lengths for adxl_sequencer        |
// | Revision : 1.0                                                         |
// +-----------------------------------------------------------------------+
package adxl_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    RST_CMD     = 3'd1,
    RST_WAIT    = 3'd2,
    CFG_CMD     = 3'd3,
    GAP         = 3'd4,
    READ        = 3'd5,
    PERIOD_WAIT = 3'd6
  } seq_state_t;

  localparam logic [7:0] CMD_WRITE      = 8'h0A;
  localparam logic [7:0] CMD_READ       = 8'h0B;
  localparam logic [7:0] REG_SOFT_RESET = 8'h1F;
  localparam logic [7:0] REG_POWER_CTL  = 8'h2D;
  localparam logic [7:0] REG_XDATA      = 8'h08;
  localparam logic [7:0] SOFT_RESET_KEY = 8'h52;
  localparam logic [7:0] MEAS_MODE      = 8'h02;
  localparam logic [2:0] WRITE_LEN      = 3'd3;
  localparam logic [2:0] READ_LEN       = 3'd5;

  function automatic logic [7:0] cmd_byte(input seq_state_t st, input logic [2:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (st)
      RST_CMD: begin
        case (idx)
          3'd0:    b = CMD_WRITE;
          3'd1:    b = REG_SOFT_RESET;
          3'd2:    b = SOFT_RESET_KEY;
          default: b = 8'h00;
        endcase
      end
      CFG_CMD: begin
        case (idx)
          3'd0:    b = CMD_WRITE;
          3'd1:    b = REG_POWER_CTL;
          3'd2:    b = MEAS_MODE;
          default: b = 8'h00;
        endcase
      end
      READ: begin
        case (idx)
          3'd0:    b = CMD_READ;
          3'd1:    b = REG_XDATA;
          default: b = 8'h00;
        endcase
      end
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic [2:0] cmd_len(input seq_state_t st);
    return (st == READ) ? READ_LEN : WRITE_LEN;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adxl_sequencer_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | adxl_sequencer_if : byte-engine handshake and chip select              |
// | Revision : 1.0                                                         |
// +-----------------------------------------------------------------------+
interface adxl_sequencer_if;
  logic       xfer_start;
  logic [7:0] tx_byte;
  logic       xfer_done;
  logic [7:0] rx_byte;
  logic       cs_n;

  modport master (output xfer_start, tx_byte, cs_n, input xfer_done, rx_byte);
  modport slave  (input xfer_start, tx_byte, cs_n, output xfer_done, rx_byte);
endinterface
`default_nettype wire

// File: rtl/cycle_timer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cycle_timer : loadable down-counter, expire high while count == 1      |
// | Revision : 1.0                                                         |
// +-----------------------------------------------------------------------+
module cycle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             expire
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  // A load of N keeps the owning state active for exactly N cycles.
  assign expire = (count == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/adxl_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | adxl_sequencer : soft-reset, measurement-mode and periodic XYZ reads   |
// | Revision : 1.0                                                         |
// +-----------------------------------------------------------------------+
module adxl_sequencer
  import adxl_pkg::*;
#(
  parameter int RESET_WAIT_CYC    = 5000,
  parameter int CS_GAP_CYC        = 8,
  parameter int SAMPLE_PERIOD_CYC = 500000,
  parameter int TIMEOUT_CYC       = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  adxl_sequencer_if.master         spi,
  output logic [7:0]               x_data,
  output logic [7:0]               y_data,
  output logic [7:0]               z_data,
  output logic                     sample_valid,
  output logic                     busy,
  output logic                     err
);

  localparam int MAX_AB  = (RESET_WAIT_CYC > CS_GAP_CYC) ? RESET_WAIT_CYC : CS_GAP_CYC;
  localparam int MAX_CD  = (SAMPLE_PERIOD_CYC > TIMEOUT_CYC) ? SAMPLE_PERIOD_CYC : TIMEOUT_CYC;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int TW      = $clog2(MAX_CYC + 1);

  localparam logic [TW-1:0] RW_LOAD  = TW'(RESET_WAIT_CYC);
  localparam logic [TW-1:0] GAP_LOAD = TW'(CS_GAP_CYC);
  localparam logic [TW-1:0] PER_LOAD = TW'(SAMPLE_PERIOD_CYC);
  localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT_CYC);

  seq_state_t    state, state_d;
  logic          cs_n_q, cs_n_d;
  logic          start_q, start_d;
  logic [7:0]    tx_q, tx_d;
  logic [2:0]    idx, idx_d;
  logic          pending, pend_d;
  logic [7:0]    cap_x, cap_x_d, cap_y, cap_y_d;
  logic [7:0]    x_d, y_d, z_d;
  logic          sv_d, err_d;
  logic          tmr_load, tmr_expire, timeout_hit;
  logic [TW-1:0] tmr_val;

  cycle_timer #(.WIDTH(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cs_n_q       <= 1'b1;
      start_q      <= 1'b0;
      tx_q         <= '0;
      idx          <= '0;
      pending      <= 1'b0;
      cap_x        <= '0;
      cap_y        <= '0;
      x_data       <= '0;
      y_data       <= '0;
      z_data       <= '0;
      sample_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= state_d;
      cs_n_q       <= cs_n_d;
      start_q      <= start_d;
      tx_q         <= tx_d;
      idx          <= idx_d;
      pending      <= pend_d;
      cap_x        <= cap_x_d;
      cap_y        <= cap_y_d;
      x_data       <= x_d;
      y_data       <= y_d;
      z_data       <= z_d;
      sample_valid <= sv_d;
      err          <= err_d;
    end
  end

  always_comb begin
    state_d     = state;
    cs_n_d      = cs_n_q;
    start_d     = 1'b0;
    tx_d        = tx_q;
    idx_d       = idx;
    pend_d      = pending;
    cap_x_d     = cap_x;
    cap_y_d     = cap_y;
    x_d         = x_data;
    y_d         = y_data;
    z_d         = z_data;
    sv_d        = 1'b0;
    err_d       = err;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    timeout_hit = 1'b0;

    case (state)
      IDLE: begin
        if (enable && !err) begin
          state_d = RST_CMD;
          cs_n_d  = 1'b0;
        end
      end
      RST_CMD, CFG_CMD, READ: begin
        // pending low marks the cs_n-fall cycle; first byte launches next
        if (!pending) begin
          start_d  = 1'b1;
          tx_d     = cmd_byte(state, idx);
          pend_d   = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = TO_LOAD;
        end else if (spi.xfer_done) begin
          if (state == READ) begin
            case (idx)
              3'd2: cap_x_d = spi.rx_byte;
              3'd3: cap_y_d = spi.rx_byte;
              3'd4: begin
                x_d  = cap_x;
                y_d  = cap_y;
                z_d  = spi.rx_byte;
                sv_d = 1'b1;
              end
              default: ;
            endcase
          end
          if (idx == cmd_len(state) - 3'd1) begin
            cs_n_d   = 1'b1;
            pend_d   = 1'b0;
            idx_d    = '0;
            tmr_load = 1'b1;
            case (state)
              RST_CMD: begin state_d = RST_WAIT;    tmr_val = RW_LOAD;  end
              CFG_CMD: begin state_d = GAP;         tmr_val = GAP_LOAD; end
              default: begin state_d = PERIOD_WAIT; tmr_val = PER_LOAD; end
            endcase
          end else begin
            idx_d    = idx + 3'd1;
            start_d  = 1'b1;
            tx_d     = cmd_byte(state, idx + 3'd1);
            tmr_load = 1'b1;
            tmr_val  = TO_LOAD;
          end
        end else if (tmr_expire) begin
          timeout_hit = 1'b1;
        end
      end
      RST_WAIT: begin
        if (tmr_expire) begin
          state_d = CFG_CMD;
          cs_n_d  = 1'b0;
        end
      end
      GAP: begin
        if (tmr_expire) begin
          state_d = READ;
          cs_n_d  = 1'b0;
        end
      end
      PERIOD_WAIT: begin
        if (tmr_expire) begin
          state_d  = GAP;
          tmr_load = 1'b1;
          tmr_val  = GAP_LOAD;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort path; a timeout still latches err even if enable drops too.
    if (timeout_hit || !enable) begin
      state_d = IDLE;
      cs_n_d  = 1'b1;
      start_d = 1'b0;
      pend_d  = 1'b0;
      idx_d   = '0;
      x_d     = x_data;
      y_d     = y_data;
      z_d     = z_data;
      sv_d    = 1'b0;
    end
    err_d = err | timeout_hit;
  end

  assign spi.cs_n       = cs_n_q;
  assign spi.xfer_start = start_q;
  assign spi.tx_byte    = tx_q;
  assign busy           = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_adxl_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_adxl_sequencer : directed bench with engine model and scoreboard    |
// | Revision : 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_adxl_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] x_data, y_data, z_data;
  logic       sample_valid, busy, err;

  adxl_sequencer_if spi ();

  adxl_sequencer #(
    .RESET_WAIT_CYC    (20),
    .CS_GAP_CYC        (4),
    .SAMPLE_PERIOD_CYC (200),
    .TIMEOUT_CYC       (50)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .spi          (spi),
    .x_data       (x_data),
    .y_data       (y_data),
    .z_data       (z_data),
    .sample_valid (sample_valid),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int cyc = 0, rem = 0, bidx = 0, starts = 0, dones = 0, svs = 0, hi_run = 0;
  int last_done_cyc = 0, s2d_cyc = 0, err_cyc = -1;
  int spur_cnt = 0, spur_seen = 0;
  logic cs_at_err = 1'b0;
  bit   withhold = 1'b0;
  logic [7:0]  rx_pat [5];
  logic [7:0]  exp_tx [$];
  logic [23:0] exp_xyz [$];
  int          gap_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    exp_tx.push_back(a);
    exp_tx.push_back(b);
    exp_tx.push_back(c);
  endtask

  task automatic push_read();
    push3(8'h0B, 8'h08, 8'h00);
    exp_tx.push_back(8'h00);
    exp_tx.push_back(8'h00);
  endtask

  // Monitor and byte-engine model, both evaluated on the falling edge.
  initial begin
    spi.xfer_done = 1'b0;
    spi.rx_byte   = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (spi.xfer_start) begin
        starts++;
        if (spi.tx_byte == 8'h2D) s2d_cyc = cyc;
        chk("tx_pending", exp_tx.size() != 0, 1);
        if (exp_tx.size() != 0) chk("tx_byte", spi.tx_byte, exp_tx.pop_front());
      end
      if (spi.cs_n) hi_run++;
      else if (hi_run != 0) begin
        gap_q.push_back(hi_run);
        hi_run = 0;
      end
      if (err && err_cyc < 0) begin
        err_cyc   = cyc;
        cs_at_err = spi.cs_n;
      end
      if (sample_valid) begin
        svs++;
        chk("sv_latency", cyc - last_done_cyc, 1);
        chk("sv_expected", exp_xyz.size() != 0, 1);
        if (exp_xyz.size() != 0) chk("xyz", {x_data, y_data, z_data}, exp_xyz.pop_front());
      end
      spi.xfer_done = 1'b0;
      if (spi.cs_n) bidx = 0;
      if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          spi.xfer_done = 1'b1;
          spi.rx_byte   = (bidx < 5) ? rx_pat[bidx] : 8'h00;
          bidx++;
          dones++;
          last_done_cyc = cyc;
        end
      end
      if (spur_cnt != spur_seen) begin
        spur_seen     = spur_cnt;
        spi.xfer_done = 1'b1;
        spi.rx_byte   = 8'hEE;
      end
      if (spi.xfer_start && !(withhold && spi.tx_byte == 8'h2D)) rem = 8;
    end
  end

  initial begin
    int g;
    int s_starts;
    rx_pat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", spi.cs_n, 1);
    chk("rst_start", spi.xfer_start, 0);
    chk("rst_tx", spi.tx_byte, 0);
    chk("rst_xyz", {x_data, y_data, z_data}, 0);
    chk("rst_sv", sample_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);

    // bring-up and first capture
    push3(8'h0A, 8'h1F, 8'h52);
    push3(8'h0A, 8'h2D, 8'h02);
    push_read();
    exp_xyz.push_back(24'h334455);
    rst = 1'b0;
    enable = 1'b1;
    g = 0;
    while (svs < 1 && g < 2000) begin @(posedge clk); g++; end
    #1;
    chk("bringup_done", svs, 1);
    chk("rst_wait_gap", (gap_q.size() >= 3) && (gap_q[1] >= 20), 1);
    chk("cfg_gap", (gap_q.size() >= 3) && (gap_q[2] >= 4), 1);
    chk("cap_xyz", {x_data, y_data, z_data}, 24'h334455);
    chk("busy_run", busy, 1);

    // second read: period cadence
    rx_pat = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    push_read();
    exp_xyz.push_back(24'hA3A4A5);
    g = 0;
    while (svs < 2 && g < 600) begin @(posedge clk); g++; end
    #1;
    chk("read2_done", svs, 2);
    chk("period_gap", (gap_q.size() >= 4) ? gap_q[3] : 0, 204);

    // spurious done during PERIOD_WAIT
    repeat (20) @(posedge clk);
    #1;
    s_starts = starts;
    spur_cnt++;
    repeat (4) @(posedge clk);
    #1;
    chk("spur_xyz", {x_data, y_data, z_data}, 24'hA3A4A5);
    chk("spur_starts", starts - s_starts, 0);
    chk("spur_cs_n", spi.cs_n, 1);
    chk("spur_busy", busy, 1);
    chk("spur_sv", svs, 2);

    // third read aborted after done #4
    rx_pat = '{8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5};
    push_read();
    g = 0;
    while (!(gap_q.size() >= 5 && bidx == 4) && g < 600) begin @(posedge clk); g++; end
    chk("abort_reached", bidx, 4);
    #1;
    enable = 1'b0;
    @(posedge clk);
    #1;
    chk("period_gap_spur", (gap_q.size() >= 5) ? gap_q[4] : 0, 204);
    chk("abort_busy", busy, 0);
    chk("abort_cs_n", spi.cs_n, 1);
    chk("abort_start", spi.xfer_start, 0);
    chk("abort_xyz", {x_data, y_data, z_data}, 24'hA3A4A5);
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_sv", svs, 2);
    chk("abort_xyz_hold", {x_data, y_data, z_data}, 24'hA3A4A5);

    // re-enable restarts at RST_CMD; engine withholds CFG byte 0x2D
    withhold = 1'b1;
    push3(8'h0A, 8'h1F, 8'h52);
    exp_tx.push_back(8'h0A);
    exp_tx.push_back(8'h2D);
    enable = 1'b1;
    g = 0;
    while (!err && g < 1000) begin @(posedge clk); g++; end
    #1;
    chk("timeout_err", err, 1);
    chk("timeout_lat", err_cyc - s2d_cyc, 50);
    chk("timeout_cs_n", cs_at_err, 1);
    chk("timeout_busy", busy, 0);
    s_starts = starts;
    repeat (100) @(posedge clk);
    #1;
    chk("err_no_start", starts - s_starts, 0);
    chk("err_sticky", err, 1);
    chk("err_cs_n", spi.cs_n, 1);
    chk("tx_queue_drained", exp_tx.size(), 0);

    // rst clears err; run to a capture, then rst mid-read
    withhold = 1'b0;
    rx_pat = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
    push3(8'h0A, 8'h1F, 8'h52);
    push3(8'h0A, 8'h2D, 8'h02);
    push_read();
    exp_xyz.push_back(24'hC3C4C5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_clears_err", err, 0);
    rst = 1'b0;
    g = 0;
    while (svs < 3 && g < 2000) begin @(posedge clk); g++; end
    #1;
    chk("read_after_rst", {x_data, y_data, z_data}, 24'hC3C4C5);
    push_read();
    g = 0;
    while (!(gap_q.size() >= 11 && bidx == 2) && g < 600) begin @(posedge clk); g++; end
    chk("midread_reached", bidx, 2);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_cs_n", spi.cs_n, 1);
    chk("mid_rst_start", spi.xfer_start, 0);
    chk("mid_rst_tx", spi.tx_byte, 0);
    chk("mid_rst_xyz", {x_data, y_data, z_data}, 0);
    chk("mid_rst_sv", sample_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", err, 0);
    exp_tx.delete();
    enable = 1'b0;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("xyz_queue_drained", exp_xyz.size(), 0);
    chk("svs_final", svs, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
